// File: rtl/instr_split_queue.sv
// rtl/instr_split_queue.sv - fetch-to-decode FIFO presenting the head entry split into MIPS fields
// Optional imm32_s/imm32_z outputs when INSTR_SPLIT_EXT_EN is defined.
module instr_split_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [5:0]      op,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [4:0]      shamt,
   output logic [5:0]      func,
   output logic [15:0]     imm16,
   output logic [25:0]     imm26,
`ifdef INSTR_SPLIT_EXT_EN
   output logic [31:0]     imm32_s,
   output logic [31:0]     imm32_z,
`endif
   output logic [CW-1:0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PC_W-1:0] pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];
   logic            push, pop;

   // Explicit wrap so that non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left unreset; out_valid masks stale contents.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem[wr_ptr_q]    <= in_pc;
         instr_mem[wr_ptr_q] <= in_instr;
      end
   end

   assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
   assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

   assign op    = out_instr[31:26];
   assign rs    = out_instr[25:21];
   assign rt    = out_instr[20:16];
   assign rd    = out_instr[15:11];
   assign shamt = out_instr[10:6];
   assign func  = out_instr[5:0];
   assign imm16 = out_instr[15:0];
   assign imm26 = out_instr[25:0];

`ifdef INSTR_SPLIT_EXT_EN
   assign imm32_s = {{16{out_instr[15]}}, out_instr[15:0]};
   assign imm32_z = {16'h0000, out_instr[15:0]};
`endif

endmodule

// File: tb/tb_instr_split_queue.sv
// tb/tb_instr_split_queue.sv - scoreboard bench for instr_split_queue
// Builds with DEPTH=3 and checks extension outputs when INSTR_SPLIT_EXT_EN is defined.
module tb_instr_split_queue;
`ifdef INSTR_SPLIT_EXT_EN
   localparam int DEPTH = 3;
`else
   localparam int DEPTH = 4;
`endif
   localparam int PC_W = 32;
   localparam int CW   = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     in_instr = '0;
   logic [PC_W-1:0] in_pc = '0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_instr;
   logic [5:0]      op;
   logic [4:0]      rs, rt, rd, shamt;
   logic [5:0]      func;
   logic [15:0]     imm16;
   logic [25:0]     imm26;
   logic [CW-1:0]   count;
`ifdef INSTR_SPLIT_EXT_EN
   logic [31:0]     imm32_s, imm32_z;
`endif

   always #5 clk = ~clk;

   instr_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .imm16(imm16), .imm26(imm26),
`ifdef INSTR_SPLIT_EXT_EN
      .imm32_s(imm32_s), .imm32_z(imm32_z),
`endif
      .count(count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of accepted entries; fields by arithmetic.
   always @(negedge clk) begin
      int   sz;
      ent_t e;
      logic [31:0] x, i16;
      sz = sbq.size();
      if (!reset) begin
         sbq.delete();
         chk("rst_out_valid", out_valid, 0);
         chk("rst_count", count, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_instr", out_instr, 0);
         chk("rst_out_pc", out_pc, 0);
      end else begin
         chk("out_valid", out_valid, sz != 0);
         chk("count", count, sz);
         chk("in_ready", in_ready, sz != DEPTH);
         x = 0;
         e.pc = 0;
         if (sz != 0) begin
            e = sbq[0];
            x = e.instr;
         end
         i16 = x % 65536;
         chk("out_pc", out_pc, e.pc);
         chk("out_instr", out_instr, x);
         chk("op", op, x / 67108864);
         chk("rs", rs, (x / 2097152) % 32);
         chk("rt", rt, (x / 65536) % 32);
         chk("rd", rd, (x / 2048) % 32);
         chk("shamt", shamt, (x / 64) % 32);
         chk("func", func, x % 64);
         chk("imm16", imm16, i16);
         chk("imm26", imm26, x % 67108864);
`ifdef INSTR_SPLIT_EXT_EN
         chk("imm32_s", imm32_s, (i16 >= 32768) ? i16 + 32'hFFFF_0000 : i16);
         chk("imm32_z", imm32_z, i16);
`endif
         if (flush) sbq.delete();
         else begin
            if (out_ready && sz != 0) void'(sbq.pop_front());
            if (in_valid && sz != DEPTH) sbq.push_back('{pc: in_pc, instr: in_instr});
         end
      end
   end

   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic idle_check();
      step(0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      repeat (DEPTH + 1) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Single push: fields of a lw instruction
      step(1, 32'h8C22_0004, 32'h3000, 0, 0);
      idle_check();
      chk("t1_valid", out_valid, 1);
      chk("t1_op", op, 32'h23);
      chk("t1_rs", rs, 1);
      chk("t1_rt", rt, 2);
      chk("t1_imm16", imm16, 32'h0004);
      chk("t1_count", count, 1);
      chk("t1_pc", out_pc, 32'h3000);
      drain();

      // Fill to full, extra push refused, then drain in order
      for (int i = 0; i < DEPTH; i++) step(1, 32'h0100_0000 + i, 32'h4000 + 4 * i, 0, 0);
      step(1, 32'hBAD0_0000, 32'hBAD0, 0, 0);
      idle_check();
      chk("t2_count_full", count, DEPTH);
      chk("t2_in_ready", in_ready, 0);
      chk("t2_head_pc", out_pc, 32'h4000);
      drain();
      chk("t2_count_empty", count, 0);

      // Steady push+pop at count=2 across several wraps
      for (int i = 0; i < 2; i++) step(1, 32'h0200_0000 + i, 32'h5000 + 4 * i, 0, 0);
      for (int i = 2; i < 12; i++) step(1, 32'h0200_0000 + i, 32'h5000 + 4 * i, 1, 0);
      idle_check();
      chk("t3_count", count, 2);
      chk("t3_head_pc", out_pc, 32'h5000 + 4 * 10);
      drain();

      // Flush with a simultaneous push
      for (int i = 0; i < 3; i++) step(1, 32'h0300_0000 + i, 32'h6000 + 4 * i, 0, 0);
      step(1, 32'hDEAD_BEEF, 32'hDEAD, 1, 1);
      idle_check();
      chk("t4_count", count, 0);
      chk("t4_valid", out_valid, 0);
      chk("t4_instr", out_instr, 0);
      idle_check();
      chk("t4_still_empty", out_valid, 0);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 2; i++) step(1, 32'h0400_0000 + i, 32'h7000 + 4 * i, 0, 0);
      step(0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("t5_valid", out_valid, 0);
      chk("t5_count", count, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("t5_in_ready", in_ready, 1);

`ifdef INSTR_SPLIT_EXT_EN
      step(1, 32'h2000_FFF0, 32'h8000, 0, 0);
      idle_check();
      chk("t6_imm32_s", imm32_s, 32'hFFFF_FFF0);
      chk("t6_imm32_z", imm32_z, 32'h0000_FFF0);
      drain();
`endif

      // Randomised traffic with occasional flushes
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
